// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown seconds timer and its BCD counter.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam int unsigned BCD_W   = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    localparam int unsigned TICK_W  = 4;

    // Saturate a raw nibble to a legal BCD digit
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/countdown_seconds_timer_bcd2_down_counter.sv
// Two-digit BCD down counter with clamped load and a decrement enable.
module bcd2_down_counter
    import countdown_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [BCD_W-1:0] load_tens,
    input  logic [BCD_W-1:0] load_ones,
    input  logic             dec,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             zero_next_c
);

    // A decrement from 01 is the one that lands on 00
    assign zero_next_c = (tens == BCD_W'(0)) && (ones == BCD_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tens <= '0;
            ones <= '0;
        end else if (load) begin
            tens <= bcd_clamp(load_tens);
            ones <= bcd_clamp(load_ones);
        end else if (dec && !((tens == '0) && (ones == '0))) begin
            if (ones == '0) begin
                ones <= BCD_MAX;
                tens <= tens - BCD_W'(1);
            end else begin
                ones <= ones - BCD_W'(1);
            end
        end
    end

endmodule

// File: rtl/countdown_seconds_timer.sv
// Countdown seconds timer: run/pause/load FSM, 100 ms tick counter and expiry pulse.
// Optional blink output enabled by defining COUNTDOWN_WARN_BLINK_EN.
module countdown_seconds_timer
    import countdown_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 10,
    parameter int unsigned WARN_SECS     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hundredMsTimeout,
    input  logic             start,
    input  logic             pause,
    input  logic             load,
    input  logic [BCD_W-1:0] loadTens,
    input  logic [BCD_W-1:0] loadOnes,
    output logic             timerEnable,
    output logic [BCD_W-1:0] secTens,
    output logic [BCD_W-1:0] secOnes,
    output logic             running,
    output logic             timeUp,
    output logic             warn
);

    if (TICKS_PER_SEC < 1 || TICKS_PER_SEC > 15) begin : g_bad_ticks
        $error("TICKS_PER_SEC out of range 1..15");
    end
    if (WARN_SECS < 1 || WARN_SECS > 99) begin : g_bad_warn
        $error("WARN_SECS out of range 1..99");
    end

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);

    state_t            state, state_next;
    logic [TICK_W-1:0] tick_cnt, tick_next;
    logic              time_up_next;
    logic              dec;
    logic              load_ok;
    logic              zero_next_c;
    logic              digits_zero;

    bcd2_down_counter u_digits (
        .clk         (clk),
        .rst         (rst),
        .load        (load_ok),
        .load_tens   (loadTens),
        .load_ones   (loadOnes),
        .dec         (dec),
        .tens        (secTens),
        .ones        (secOnes),
        .zero_next_c (zero_next_c)
    );

    assign digits_zero = (secTens == '0) && (secOnes == '0);
    assign running     = (state == RUN);
    assign timerEnable = (state == RUN);

    // Next state, tick counting and load acceptance; starting from 00 is refused
    always_comb begin
        state_next   = state;
        tick_next    = tick_cnt;
        time_up_next = 1'b0;
        dec          = 1'b0;
        load_ok      = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    load_ok   = 1'b1;
                    tick_next = '0;
                end else if (start && !digits_zero) begin
                    state_next = RUN;
                    tick_next  = '0;
                end
            end
            RUN: begin
                if (hundredMsTimeout) begin
                    if (tick_cnt < TICK_LAST) begin
                        tick_next = tick_cnt + TICK_W'(1);
                    end else begin
                        tick_next = '0;
                        dec       = 1'b1;
                    end
                end
                if (dec && zero_next_c) begin
                    state_next   = EXPIRED;
                    time_up_next = 1'b1;
                end else if (pause) begin
                    state_next = PAUSED;
                end
            end
            PAUSED: begin
                if (load) begin
                    load_ok   = 1'b1;
                    tick_next = '0;
                end else if (start && !digits_zero) begin
                    state_next = RUN;
                end
            end
            EXPIRED: begin
                if (load) begin
                    load_ok    = 1'b1;
                    tick_next  = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                tick_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            timeUp   <= 1'b0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_next;
            timeUp   <= time_up_next;
        end
    end

`ifdef COUNTDOWN_WARN_BLINK_EN
    logic [6:0] rem;
    logic [6:0] rem_next;
    logic       warn_next;

    // Blink only while the post-update remaining seconds are within the warning window
    always_comb begin
        rem       = 7'(secTens) * 7'd10 + 7'(secOnes);
        rem_next  = dec ? (rem - 7'd1) : rem;
        warn_next = 1'b0;
        if ((state_next == RUN || state_next == PAUSED) && !load_ok
            && (rem_next <= 7'(WARN_SECS))) begin
            warn_next = (state == RUN && hundredMsTimeout) ? !warn : warn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            warn <= 1'b0;
        end else begin
            warn <= warn_next;
        end
    end
`else
    assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_seconds_timer.sv
// Self-checking bench for countdown_seconds_timer: directed scenarios plus random traffic vs. a seconds-level model.
module tb_countdown_seconds_timer;

    localparam int TPS = 10;
    localparam int WS  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pulse = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       load = 1'b0;
    logic [3:0] lt = 4'd0;
    logic [3:0] lo = 4'd0;
    logic       timer_enable;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       time_up;
    logic       warn;

    int errors = 0;
    int checks = 0;

    // Reference model: remaining time as an integer, plus mode flags
    int m_secs  = 0;
    int m_ticks = 0;
    bit m_run = 0, m_paused = 0, m_expired = 0, m_timeup = 0, m_warn = 0;

    countdown_seconds_timer #(.TICKS_PER_SEC(TPS), .WARN_SECS(WS)) dut (
        .clk              (clk),
        .rst              (rst),
        .hundredMsTimeout (pulse),
        .start            (start),
        .pause            (pause),
        .load             (load),
        .loadTens         (lt),
        .loadOnes         (lo),
        .timerEnable      (timer_enable),
        .secTens          (sec_tens),
        .secOnes          (sec_ones),
        .running          (running),
        .timeUp           (time_up),
        .warn             (warn)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 9 : int'(d);
    endfunction

    function automatic void model_step(input bit r, input bit s, input bit p, input bit l,
                                       input logic [3:0] a, input logic [3:0] b, input bit pl);
        bit idle, counted, loaded;
        m_timeup = 0;
        if (r) begin
            m_secs = 0; m_ticks = 0; m_run = 0; m_paused = 0; m_expired = 0; m_warn = 0;
            return;
        end
        idle    = !(m_run || m_paused || m_expired);
        counted = m_run && pl;
        loaded  = 0;
        if (m_run) begin
            if (pl) begin
                if (m_ticks < TPS - 1) m_ticks++;
                else begin
                    m_ticks = 0;
                    m_secs--;
                    if (m_secs == 0) begin
                        m_run = 0; m_expired = 1; m_timeup = 1;
                    end
                end
            end
            if (m_run && p) begin
                m_run = 0; m_paused = 1;
            end
        end else if (l) begin
            m_secs = clamp9(a) * 10 + clamp9(b);
            m_ticks = 0; m_expired = 0; loaded = 1;
        end else if (s && m_secs != 0 && (idle || m_paused)) begin
            if (idle) m_ticks = 0;
            m_run = 1; m_paused = 0;
        end
`ifdef COUNTDOWN_WARN_BLINK_EN
        if ((m_run || m_paused) && !loaded && m_secs <= WS) m_warn = counted ? !m_warn : m_warn;
        else m_warn = 0;
`else
        m_warn = 0;
`endif
    endfunction

    // One clock: drive inputs, advance model at the edge, compare all outputs just after it
    task automatic cyc(input bit r, input bit s, input bit p, input bit l,
                       input logic [3:0] a, input logic [3:0] b, input bit pl);
        rst = r; start = s; pause = p; load = l; lt = a; lo = b; pulse = pl;
        @(posedge clk);
        model_step(r, s, p, l, a, b, pl);
        #1;
        check("outs", {20'd0, sec_tens, sec_ones, running, timer_enable, time_up, warn},
              {20'd0, 4'(m_secs / 10), 4'(m_secs % 10), m_run, m_run, m_timeup, m_warn});
    endtask

    task automatic idle_cyc();
        cyc(0, 0, 0, 0, 4'd0, 4'd0, 0);
    endtask

    task automatic do_load(input logic [3:0] a, input logic [3:0] b);
        cyc(0, 0, 0, 1, a, b, 0);
    endtask

    task automatic do_start();
        cyc(0, 1, 0, 0, 4'd0, 4'd0, 0);
    endtask

    task automatic do_pause();
        cyc(0, 0, 1, 0, 4'd0, 4'd0, 0);
    endtask

    // n pulses, each followed by 4 quiet cycles
    task automatic pulse_gap(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, 0, 0, 4'd0, 4'd0, 1);
            repeat (4) idle_cyc();
        end
    endtask

    initial begin
        cyc(1, 0, 0, 0, 4'd0, 4'd0, 0);
        cyc(1, 0, 0, 0, 4'd0, 4'd0, 0);
        check("rst_digits", {sec_tens, sec_ones}, 8'h00);
        check("rst_enable", {timer_enable, running, time_up, warn}, 4'b0000);

        // 03 -> 00 with a single expiry pulse
        do_load(4'd0, 4'd3);
        do_start();
        check("t1_running", running, 1'b1);
        pulse_gap(10);
        check("t1_02", {sec_tens, sec_ones}, 8'h02);
        pulse_gap(10);
        check("t1_01", {sec_tens, sec_ones}, 8'h01);
        pulse_gap(9);
        cyc(0, 0, 0, 0, 4'd0, 4'd0, 1);
        check("t1_timeup", {time_up, timer_enable, sec_tens, sec_ones}, {1'b1, 1'b0, 8'h00});
        idle_cyc();
        check("t1_timeup_once", time_up, 1'b0);
        do_start();
        check("t1_start_ignored", running, 1'b0);

        // Borrow 10 -> 09
        do_load(4'd1, 4'd0);
        do_start();
        pulse_gap(10);
        check("t2_borrow", {sec_tens, sec_ones}, 8'h09);
        do_pause();

        // Clamp and decrement from 99
        do_load(4'hC, 4'hF);
        check("t3_clamp", {sec_tens, sec_ones}, 8'h99);
        do_start();
        pulse_gap(10);
        check("t3_98", {sec_tens, sec_ones}, 8'h98);
        do_load(4'd0, 4'd1);
        check("t3_load_in_run", {sec_tens, sec_ones}, 8'h98);
        do_pause();

        // Partial second survives a pause
        do_load(4'd0, 4'd5);
        do_start();
        pulse_gap(4);
        do_pause();
        pulse_gap(20);
        check("t4_paused_hold", {sec_tens, sec_ones, running}, {8'h05, 1'b0});
        do_start();
        pulse_gap(5);
        check("t4_no_dec_yet", {sec_tens, sec_ones}, 8'h05);
        pulse_gap(1);
        check("t4_04", {sec_tens, sec_ones}, 8'h04);

        // Start from 00 refused
        cyc(1, 0, 0, 0, 4'd0, 4'd0, 0);
        do_load(4'd0, 4'd0);
        do_start();
        check("t5_zero_start", {running, time_up}, 2'b00);

        // Reset mid-run
        do_load(4'd0, 4'd2);
        do_start();
        pulse_gap(12);
        cyc(1, 0, 0, 0, 4'd0, 4'd0, 0);
        check("t6_rst", {sec_tens, sec_ones, running, timer_enable, time_up, warn}, 12'h000);
        idle_cyc();
        check("t6_no_timeup", time_up, 1'b0);

        // Load beats start in IDLE
        cyc(0, 1, 0, 1, 4'd0, 4'd5, 0);
        check("t7_load_wins", {sec_tens, sec_ones, running}, {8'h05, 1'b0});
        do_start();
        check("t7_restart", running, 1'b1);

        // Warning window walk: 07 down to expiry
        do_pause();
        do_load(4'd0, 4'd7);
        do_start();
        pulse_gap(75);
        check("t8_expired", {sec_tens, sec_ones, warn}, {8'h00, 1'b0});

        // Random traffic
        for (int i = 0; i < 6000; i++) begin
            int r;
            logic [3:0] a, b;
            bit s, p, l, pl, rs;
            r  = int'($urandom_range(0, 99));
            rs = ($urandom_range(0, 399) == 0);
            s  = (r < 4);
            p  = (r >= 4 && r < 6);
            l  = (r >= 6 && r < 9);
            pl = ($urandom_range(0, 2) == 0);
            a  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            b  = 4'($urandom_range(0, 15));
            cyc(rs, s, p, l, a, b, pl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
